// File: rtl/modc_array.sv
// modc_array: NUM_CH-channel round-robin arbiter feeding one registered
// {i1, i2} output word tagged with its source channel index.
// Optional feature macro: MODC_ARRAY_PARITY_EN adds the registered even-parity
// output o_par (^{o1, o_par} == 0).
module modc_array #(
  parameter  int NUM_CH = 4,
  parameter  int A      = 8,
  parameter  int B      = 9,
  localparam int CHW    = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ch_vld,
  output logic [NUM_CH-1:0]   ch_rdy,
  input  logic [NUM_CH*A-1:0] ch_i1,
  input  logic [NUM_CH*B-1:0] ch_i2,
  output logic                o_vld,
  input  logic                o_rdy,
  output logic [A+B-1:0]      o1,
  output logic [CHW-1:0]      o_ch
`ifdef MODC_ARRAY_PARITY_EN
  ,
  output logic                o_par
`endif
);

  // Output register and round-robin pointer
  logic              r_vld;
  logic [A+B-1:0]    r_o1;
  logic [CHW-1:0]    r_ch;
  logic [CHW-1:0]    r_ptr;

  // Arbitration and handshake nets
  logic [NUM_CH-1:0] w_mask;
  logic [NUM_CH-1:0] w_hi;
  logic [NUM_CH-1:0] w_src;
  logic [CHW-1:0]    w_gnt;
  logic              w_any;
  logic              w_load;
  logic              w_xfer;
  logic [A-1:0]      w_i1;
  logic [B-1:0]      w_i2;
  logic [A+B-1:0]    w_word;
  logic [CHW-1:0]    w_ptr_nxt;

  assign w_any  = |ch_vld;
  assign w_load = ~r_vld | o_rdy;
  // No handshake is offered while reset is asserted.
  assign w_xfer = w_load & w_any & ~rst;

  // Mark channels at or above the pointer; these win over wrapped-around ones
  always_comb begin
    w_mask = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_mask[k] = (CHW'(k) >= r_ptr);
    end
  end

  assign w_hi  = ch_vld & w_mask;
  // The rotating search is split into "ptr..top" then "0..ptr-1": if any valid
  // channel sits at or above ptr the lowest of those wins, else the lowest overall.
  assign w_src = (|w_hi) ? w_hi : ch_vld;

  // Pick the lowest set bit of the search vector as the grant
  always_comb begin
    w_gnt = '0;
    for (int unsigned k = NUM_CH; k > 0; k--) begin
      if (w_src[k-1]) begin
        w_gnt = CHW'(k - 1);
      end
    end
  end

  // One-hot ready to the granted channel whenever the output register can load
  always_comb begin
    ch_rdy = '0;
    if (w_xfer) begin
      ch_rdy[w_gnt] = 1'b1;
    end
  end

  assign w_i1      = ch_i1[w_gnt*A +: A];
  assign w_i2      = ch_i2[w_gnt*B +: B];
  assign w_word    = {w_i1, w_i2};
  assign w_ptr_nxt = (w_gnt == CHW'(NUM_CH - 1)) ? '0 : w_gnt + CHW'(1);

  // Output register: load on transfer, drain to invalid when nothing to grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_o1  <= '0;
      r_ch  <= '0;
      r_ptr <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_vld <= 1'b1;
        r_o1  <= w_word;
        r_ch  <= w_gnt;
        r_ptr <= w_ptr_nxt;
      end else begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_vld = r_vld;
  assign o1    = r_o1;
  assign o_ch  = r_ch;

`ifdef MODC_ARRAY_PARITY_EN
  logic r_par;

  // Parity bit captured alongside o1 so that {o1, o_par} has even parity
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_load && w_any) begin
      r_par <= ^w_word;
    end
  end

  assign o_par = r_par;
`endif

endmodule

// File: tb/tb_modc_array.sv
// tb_modc_array: randomized and directed stimulus for modc_array, checked
// every cycle against a behavioural arbiter/output-register model.
module tb_modc_array;

  localparam int NUM_CH = 4;
  localparam int A      = 8;
  localparam int B      = 9;
  localparam int CHW    = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_CH-1:0]   ch_vld;
  logic [NUM_CH-1:0]   ch_rdy;
  logic [NUM_CH*A-1:0] ch_i1;
  logic [NUM_CH*B-1:0] ch_i2;
  logic                o_vld;
  logic                o_rdy;
  logic [A+B-1:0]      o1;
  logic [CHW-1:0]      o_ch;
`ifdef MODC_ARRAY_PARITY_EN
  logic                o_par;
`endif

  modc_array #(.NUM_CH(NUM_CH), .A(A), .B(B)) dut (
    .clk    (clk),
    .rst    (rst),
    .ch_vld (ch_vld),
    .ch_rdy (ch_rdy),
    .ch_i1  (ch_i1),
    .ch_i2  (ch_i2),
    .o_vld  (o_vld),
    .o_rdy  (o_rdy),
    .o1     (o1),
    .o_ch   (o_ch)
`ifdef MODC_ARRAY_PARITY_EN
    ,
    .o_par  (o_par)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_ptr;
  int m_vld;
  int m_o1;
  int m_ch;
  int m_par;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotating search from the model pointer; -1 when nothing is valid
  function automatic int m_grant(input int vld);
    for (int i = 0; i < NUM_CH; i++) begin
      int idx;
      idx = (m_ptr + i) % NUM_CH;
      if (((vld >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  function automatic int field1(input int g);
    return int'((ch_i1 >> (g * A)) & 32'hFF);
  endfunction

  function automatic int field2(input int g);
    return int'((ch_i2 >> (g * B)) & 32'h1FF);
  endfunction

  function automatic int exp_rdy();
    int g;
    g = m_grant(int'(ch_vld));
    if (rst || g < 0) return 0;
    if (!(m_vld == 0 || o_rdy)) return 0;
    return 1 << g;
  endfunction

  // One clock: inputs already driven; check ready, clock, advance model, check outputs
  task automatic cycle();
    int g;
    int ld;
    #1;
    check("ch_rdy", int'(ch_rdy), exp_rdy());
    g  = m_grant(int'(ch_vld));
    ld = (m_vld == 0 || o_rdy) ? 1 : 0;
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_o1 = 0; m_ch = 0; m_par = 0; m_ptr = 0;
    end else if (ld != 0) begin
      if (g >= 0) begin
        m_o1  = (field1(g) << B) | field2(g);
        m_ch  = g;
        m_vld = 1;
        m_par = $countones(m_o1) & 1;
        m_ptr = (g + 1) % NUM_CH;
      end else begin
        m_vld = 0;
      end
    end
    #1;
    check("o_vld", int'(o_vld), m_vld);
    check("o1", int'(o1), m_o1);
    check("o_ch", int'(o_ch), m_ch);
`ifdef MODC_ARRAY_PARITY_EN
    check("o_par", int'(o_par), m_par);
`endif
    @(negedge clk);
  endtask

  task automatic rand_data();
    ch_i1 = {$urandom, $urandom};
    ch_i2 = {$urandom, $urandom};
  endtask

  initial begin
    int seq [8];
    logic [A+B-1:0] held;
    m_ptr = 0; m_vld = 0; m_o1 = 0; m_ch = 0; m_par = 0;
    rst = 1'b1; ch_vld = 4'hF; o_rdy = 1'b1;
    rand_data();
    @(negedge clk);

    // Reset held two cycles with all channels requesting
    repeat (2) begin
      cycle();
      check("rst_vld", int'(o_vld), 0);
      check("rst_o1", int'(o1), 0);
      check("rst_rdy", int'(ch_rdy), 0);
    end

    // Round-robin with everything valid: first grant is channel 0
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      cycle();
      seq[i] = int'(o_ch);
      check("rr_vld", int'(o_vld), 1);
    end
    for (int i = 0; i < 8; i++) check("rr_seq", seq[i], i % 4);

    // Single channel 2 with known data
    ch_vld = 4'b0100;
    ch_i1[2*A +: A] = 8'hA5;
    ch_i2[2*B +: B] = 9'h1C3;
    cycle();
    check("single_o1", int'(o1), 32'h14BC3);
    check("single_ch", int'(o_ch), 2);
`ifdef MODC_ARRAY_PARITY_EN
    check("single_par", int'(o_par), 1);
`endif

    // Pointer is now 3: 0101 grants 0, then 2
    ch_vld = 4'b0101;
    rand_data();
    cycle();
    check("wrap_ch0", int'(o_ch), 0);
    cycle();
    check("wrap_ch2", int'(o_ch), 2);

    // Backpressure with channel 1 pending
    ch_vld = 4'h2;
    o_rdy  = 1'b0;
    held   = o1;
    repeat (3) begin
      cycle();
      check("bp_rdy", int'(ch_rdy), 0);
      check("bp_o1", int'(o1), int'(held));
      check("bp_ch", int'(o_ch), 2);
    end
    o_rdy = 1'b1;
    #1;
    check("bp_release_rdy", int'(ch_rdy), 4'b0010);
    cycle();
    check("bp_load_ch1", int'(o_ch), 1);

    // Reset in the middle of a stall drops the held word
    o_rdy = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    check("rst_stall_vld", int'(o_vld), 0);
    rst = 1'b0; ch_vld = 4'h0; o_rdy = 1'b1;
    cycle();
    check("rst_stall_gone", int'(o_vld), 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      ch_vld = 4'($urandom);
      o_rdy  = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 99) == 0);
      rand_data();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/modc_array.md
# modc_array

Multi-channel successor to the fixed three-instance `modc` wrapper. Accepts `NUM_CH` independent input channels, each carrying an `A`-bit and a `B`-bit field under a valid/ready handshake. A round-robin arbiter grants one channel per cycle. The granted channel's fields are concatenated into a single registered `A+B`-bit output tagged with its channel index. The block sits between per-channel producers and one shared downstream consumer.

## Interface
- `NUM_CH`, 4: number of input channels, 2..16.
- `A`, 8: width of the `i1` field per channel, ≥1.
- `B`, 9: width of the `i2` field per channel, ≥1.
- `CHW`, derived as `$clog2(NUM_CH)`: width of the channel tag. Not overridden.

Ports (clock and reset first):
- `clk` input 1: sole clock; all flops are on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `ch_vld` input `NUM_CH`: per-channel valid.
- `ch_rdy` output `NUM_CH`: per-channel ready; one-hot or zero.
- `ch_i1` input `NUM_CH*A`: packed; channel k occupies `[k*A +: A]`.
- `ch_i2` input `NUM_CH*B`: packed; channel k occupies `[k*B +: B]`.
- `o_vld` output 1: output register holds valid data.
- `o_rdy` input 1: downstream accepts.
- `o1` output `A+B`: `{i1, i2}` of the granted channel.
- `o_ch` output `CHW`: index of the channel that produced `o1`.
- `o_par` output 1: present only with `MODC_ARRAY_PARITY_EN`.

## Operation
- Output stage is a single register: `o1`, `o_ch`, `o_vld` (plus `o_par` when enabled).
- `load = ~o_vld | o_rdy`.
- Arbiter:
  - Round-robin pointer `ptr` in `0..NUM_CH-1`.
  - Grant `g` is the first index with `ch_vld` set, searching `ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1`.
  - `any = |ch_vld`.
- Handshake:
  - `ch_rdy[g] = load & any`; all other `ch_rdy` bits are 0.
  - `ch_rdy` is combinational from `ch_vld`, `o_vld` and `o_rdy`.
  - A transfer on channel k occurs when `ch_vld[k] & ch_rdy[k]`.
- On a transfer:
  - `o1 <= {ch_i1[g], ch_i2[g]}`, `o_ch <= g`, `o_vld <= 1`.
  - `ptr <= (g == NUM_CH-1) ? 0 : g+1`.
- When `load & ~any`: `o_vld <= 0`; `o1` and `o_ch` hold; `ptr` holds.
- When `~load` (stall): all state holds; `ch_rdy` is all zero.
- Downstream transfer: `o_vld & o_rdy`.
- Simultaneous downstream transfer and new grant in one cycle is allowed; this gives full throughput of one word per cycle.
- Upstream may drop `ch_vld` without a handshake. The block requires no upstream stability except during the cycle of the transfer.
- Width rule: `o1` is exactly `A+B` bits, with `i1` in the MSBs. No padding and no truncation.

## Timing
- Latency: a transfer in cycle n appears on `o1`/`o_vld` in cycle n+1.
- Throughput: 1 word per cycle with `o_rdy` held high.
- Fairness: with all channels continuously valid, grants rotate 0,1,…,`NUM_CH-1`,0. Each channel is starved for at most `NUM_CH-1` consecutive grants.
- Reset (rst high at a rising edge) forces:
  - `o_vld=0`, `o1=0`, `o_ch=0`, `o_par=0`, `ptr=0`.
  - `ch_rdy` is 0 while `rst` is high.
- Reset during a stall discards the held word. No transfer completes in a reset cycle.
- First cycle after reset: `ptr=0`, so channel 0 has priority.

## Configuration
- `MODC_ARRAY_PARITY_EN` defined:
  - Adds output `o_par`, registered alongside `o1`.
  - `o_par = ^{ch_i1[g], ch_i2[g]}`, i.e. even parity: `^{o1, o_par} == 0`.
  - Reset value 0; holds on stall.
- `MODC_ARRAY_PARITY_EN` undefined: port `o_par` and its flop do not exist. All other behaviour is identical.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `ch_vld=4'hF` → `o_vld=0`, `o1=0`, `o_ch=0`, `ch_rdy=0` throughout. First grant after release is channel 0.
- **Single channel:** `NUM_CH=4`, `A=8`, `B=9`, ch2 `i1=8'hA5`, `i2=9'h1C3`, `o_rdy=1` → next cycle `o1=17'h14BC3`, `o_ch=2`, `o_vld=1`. With `MODC_ARRAY_PARITY_EN`, `o_par=1`.
- **Round-robin:** `ch_vld=4'hF` held, `o_rdy=1` for 8 cycles → `o_ch` sequence 0,1,2,3,0,1,2,3 with `o_vld` continuously 1.
- **Skip and wrap:** `ptr=3`, `ch_vld=4'b0101` → grant 0, `ptr` becomes 1. Next grant 2, `ptr` becomes 3.
- **Backpressure:** `o_vld=1`, `o_rdy=0` for 3 cycles with `ch_vld=4'h2` → `ch_rdy=0`, `o1`/`o_ch` stable. Raising `o_rdy` completes the held word and loads ch1 in the same cycle.
- **Reset mid-stall:** `o_vld=1`, `o_rdy=0`, assert `rst` for 1 cycle → `o_vld=0`, `ptr=0`, and the held word never appears downstream.
